// File: rtl/awg_pkg.sv
// Shared types and default widths for the AWG frequency sweep controller.
package awg_pkg;

  localparam int FREQ_W_DEF  = 16;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    FIN  = 2'd3
  } awg_state_e;

endpackage

// File: rtl/awg_step_calc.sv
// Next sweep frequency: one step toward tgt, clamped to tgt on overshoot or
// on carry/borrow out of the FREQ_W-bit range.
module awg_step_calc
  import awg_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic [FREQ_W-1:0] cur,
  input  logic [FREQ_W-1:0] step,
  input  logic [FREQ_W-1:0] tgt,
  input  logic              up,
  output logic [FREQ_W-1:0] nxt
);

  logic [FREQ_W:0] sum;
  logic            pass;

  always_comb begin
    sum  = up ? ({1'b0, cur} + {1'b0, step}) : ({1'b0, cur} - {1'b0, step});
    // the extra bit flags wrap in either direction
    pass = up ? (sum[FREQ_W] || (sum[FREQ_W-1:0] > tgt))
              : (sum[FREQ_W] || (sum[FREQ_W-1:0] < tgt));
    nxt  = pass ? tgt : sum[FREQ_W-1:0];
  end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Stepped frequency sweep controller; frequency updates land only at the
// generator's phase-zero crossing. Ping-pong mode: define AWG_SWEEP_PINGPONG_EN.
module awg_sweep_ctrl
  import awg_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_start,
  input  logic [FREQ_W-1:0]  cfg_stop,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef AWG_SWEEP_PINGPONG_EN
  input  logic               cfg_pingpong,
`endif
  input  logic               start,
  input  logic               abort,
  input  logic               phase_wrap,
  output logic [FREQ_W-1:0]  freq,
  output logic               freq_upd,
  output logic               busy,
  output logic               done
);

  awg_state_e         state;
  logic [FREQ_W-1:0]  start_r, stop_r, step_r;
  logic [DWELL_W-1:0] dwell_r, dwell_cnt, dwell_m1;
  logic               up_r;
  logic [FREQ_W-1:0]  tgt_r, calc_tgt, nxt;
  logic               calc_up, at_tgt, last, swap_now;

`ifdef AWG_SWEEP_PINGPONG_EN
  logic               pp_r;
  logic [FREQ_W-1:0]  org_r;
  // endpoint swap happens on the dwell that lands on the current target
  assign swap_now = pp_r && at_tgt && (state == RUN);
  assign calc_tgt = swap_now ? org_r : tgt_r;
`else
  assign tgt_r    = stop_r;
  assign swap_now = 1'b0;
  assign calc_tgt = tgt_r;
`endif

  assign calc_up   = swap_now ? ~up_r : up_r;
  assign cfg_ready = (state == IDLE);
  assign at_tgt    = (freq == tgt_r);
  assign dwell_m1  = (dwell_r == '0) ? '0 : dwell_r - 1'b1;
  assign last      = (dwell_cnt >= dwell_m1);

  awg_step_calc #(.FREQ_W(FREQ_W)) u_step (
    .cur  (freq),
    .step (step_r),
    .tgt  (calc_tgt),
    .up   (calc_up),
    .nxt  (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      freq      <= '0;
      freq_upd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_r   <= '0;
      stop_r    <= '0;
      step_r    <= '0;
      dwell_r   <= '0;
      dwell_cnt <= '0;
      up_r      <= 1'b0;
`ifdef AWG_SWEEP_PINGPONG_EN
      pp_r      <= 1'b0;
      tgt_r     <= '0;
      org_r     <= '0;
`endif
    end else begin
      freq_upd <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            start_r <= cfg_start;
            stop_r  <= cfg_stop;
            step_r  <= cfg_step;
            dwell_r <= cfg_dwell;
`ifdef AWG_SWEEP_PINGPONG_EN
            pp_r    <= cfg_pingpong;
`endif
          end
          // launch uses the configuration already latched
          if (start && !abort && (step_r != '0)) begin
            freq      <= start_r;
            freq_upd  <= 1'b1;
            busy      <= 1'b1;
            up_r      <= (start_r <= stop_r);
            dwell_cnt <= '0;
            state     <= RUN;
`ifdef AWG_SWEEP_PINGPONG_EN
            tgt_r     <= stop_r;
            org_r     <= start_r;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!last) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end else if (at_tgt && !swap_now) begin
            state <= FIN;
          end else begin
            if (swap_now) up_r <= ~up_r;
`ifdef AWG_SWEEP_PINGPONG_EN
            if (swap_now) begin
              tgt_r <= org_r;
              org_r <= tgt_r;
            end
`endif
            // a wrap on the final dwell cycle counts as the PEND wrap
            if (phase_wrap) begin
              freq      <= nxt;
              freq_upd  <= (nxt != freq);
              dwell_cnt <= '0;
            end else begin
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (phase_wrap) begin
            freq      <= nxt;
            freq_upd  <= (nxt != freq);
            dwell_cnt <= '0;
            state     <= RUN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= !abort;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed scoreboard bench for awg_sweep_ctrl; ping-pong case runs when
// AWG_SWEEP_PINGPONG_EN is defined.
module tb_awg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, cfg_dwell = '0;
`ifdef AWG_SWEEP_PINGPONG_EN
  logic        cfg_pingpong = 1'b0;
`endif
  logic        start = 1'b0, abort = 1'b0, phase_wrap = 1'b0;
  logic [15:0] freq;
  logic        freq_upd, busy, done;

  typedef struct {
    logic [15:0] f;
    bit          chk_wrap;
  } exp_t;

  exp_t q[$];
  int   errs = 0, chks = 0, done_cnt = 0, pcnt = 0;
  bit   pw_en = 1'b1;

  awg_sweep_ctrl #(.FREQ_W(16), .DWELL_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
`ifdef AWG_SWEEP_PINGPONG_EN
    .cfg_pingpong (cfg_pingpong),
`endif
    .start      (start),
    .abort      (abort),
    .phase_wrap (phase_wrap),
    .freq       (freq),
    .freq_upd   (freq_upd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // free-running phase-zero pulse, one cycle in eight
  initial forever begin
    @(negedge clk);
    pcnt++;
    phase_wrap = pw_en && (pcnt % 8 == 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every freq_upd
  initial forever begin
    bit   w;
    exp_t e;
    @(posedge clk);
    w = phase_wrap;
    #1;
    if (rst_n && freq_upd) begin
      if (q.size() == 0) begin
        check("unexpected_freq_upd", {16'd0, freq}, 32'hffff_ffff);
      end else begin
        e = q.pop_front();
        check("freq_seq", {16'd0, freq}, {16'd0, e.f});
        if (e.chk_wrap) check("upd_after_wrap", {31'd0, w}, 32'd1);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic cfg(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                     input logic [15:0] dw, input bit pp);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw;
`ifdef AWG_SWEEP_PINGPONG_EN
    cfg_pingpong = pp;
`else
    if (pp) $display("note: ping-pong request ignored in this build");
`endif
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push(input logic [15:0] f, input bit w);
    exp_t e;
    e.f = f; e.chk_wrap = w;
    q.push_back(e);
  endtask

  task automatic wait_quiet(input string nm, input int maxc);
    int n = 0;
    while ((busy || q.size() != 0) && n < maxc) begin
      @(negedge clk); n++;
    end
    check({nm, "_timeout"}, {31'd0, n >= maxc}, 32'd0);
  endtask

  task automatic wait_freq(input string nm, input logic [15:0] f, input int maxc);
    int n = 0;
    while (freq !== f && n < maxc) begin
      @(negedge clk); n++;
    end
    check({nm, "_timeout"}, {31'd0, n >= maxc}, 32'd0);
  endtask

  initial begin
    int d0;
    #12;
    check("rst_freq", {16'd0, freq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_upd", {31'd0, freq_upd}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // up sweep
    cfg(16'd100, 16'd130, 16'd10, 16'd4, 1'b0);
    d0 = done_cnt;
    push(16'd100, 1'b0); push(16'd110, 1'b1); push(16'd120, 1'b1); push(16'd130, 1'b1);
    pulse_start();
    check("up_busy", {31'd0, busy}, 32'd1);
    wait_quiet("up", 300);
    repeat (3) @(negedge clk);
    check("up_done_cnt", done_cnt - d0, 32'd1);
    check("up_busy_after", {31'd0, busy}, 32'd0);
    check("up_freq_hold", {16'd0, freq}, 32'd130);

    // clamp at top of range
    cfg(16'd65530, 16'd65535, 16'd10, 16'd2, 1'b0);
    d0 = done_cnt;
    push(16'd65530, 1'b0); push(16'd65535, 1'b1);
    pulse_start();
    wait_quiet("clamp", 200);
    repeat (3) @(negedge clk);
    check("clamp_done_cnt", done_cnt - d0, 32'd1);
    check("clamp_freq", {16'd0, freq}, 32'd65535);

    // down sweep aborted in PEND
    cfg(16'd500, 16'd100, 16'd100, 16'd3, 1'b0);
    d0 = done_cnt;
    push(16'd500, 1'b0); push(16'd400, 1'b1);
    pulse_start();
    wait_freq("down", 16'd400, 200);
    pw_en = 1'b0;
    repeat (6) @(negedge clk);
    check("down_busy_pend", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("abort_freq", {16'd0, freq}, 32'd400);
    @(negedge clk); abort = 1'b0;
    pw_en = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_q_empty", q.size(), 32'd0);

    // step of zero is a no-op
    cfg(16'd0, 16'd10, 16'd0, 16'd1, 1'b0);
    pulse_start();
    repeat (5) @(negedge clk);
    check("step0_busy", {31'd0, busy}, 32'd0);

    // abort wins over start in IDLE
    cfg(16'd100, 16'd130, 16'd10, 16'd4, 1'b0);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // cfg and start while busy are ignored
    d0 = done_cnt;
    push(16'd100, 1'b0); push(16'd110, 1'b1); push(16'd120, 1'b1); push(16'd130, 1'b1);
    pulse_start();
    check("busy_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    cfg(16'd0, 16'd1000, 16'd1, 16'd1, 1'b0);
    pulse_start();
    wait_quiet("busycfg", 300);
    repeat (3) @(negedge clk);
    check("busycfg_done_cnt", done_cnt - d0, 32'd1);
    check("busycfg_freq", {16'd0, freq}, 32'd130);

    // reset mid-sweep, no clock edge needed
    cfg(16'd100, 16'd200, 16'd10, 16'd20, 1'b0);
    push(16'd100, 1'b0); push(16'd110, 1'b1);
    pulse_start();
    wait_freq("rstmid", 16'd110, 200);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_freq", {16'd0, freq}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_q_empty", q.size(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    repeat (4) @(negedge clk);
    check("rstmid_cfg_cleared", {31'd0, busy}, 32'd0);

`ifdef AWG_SWEEP_PINGPONG_EN
    cfg(16'd0, 16'd20, 16'd10, 16'd2, 1'b1);
    d0 = done_cnt;
    push(16'd0, 1'b0); push(16'd10, 1'b1); push(16'd20, 1'b1); push(16'd10, 1'b1);
    push(16'd0, 1'b1); push(16'd10, 1'b1); push(16'd20, 1'b1);
    pulse_start();
    begin
      int n = 0;
      while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
      check("pp_timeout", {31'd0, n >= 400}, 32'd0);
    end
    check("pp_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (20) @(negedge clk);
    check("pp_busy_after", {31'd0, busy}, 32'd0);
    check("pp_no_done", done_cnt - d0, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/awg_sweep_ctrl.md
AWG_SWEEP_CTRL -- requirements
Module: awg_sweep_ctrl

Interface
REQ-001 SHALL have parameter FREQ_W, default 16, meaning the width of the frequency word driven to the waveform generator.
REQ-002 SHALL have parameter DWELL_W, default 16, meaning the width of the dwell counter in clk cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid, input, 1: sweep configuration offered.
REQ-006 SHALL have port cfg_ready, output, 1: configuration accepted when high with cfg_valid.
REQ-007 SHALL have ports cfg_start, cfg_stop and cfg_step, input, FREQ_W each: the sweep start word, stop word and step magnitude.
REQ-008 SHALL have port cfg_dwell, input, DWELL_W: clk cycles spent at each frequency.
REQ-009 SHALL have port start, input, 1: single-cycle pulse that launches the sweep.
REQ-010 SHALL have port abort, input, 1: single-cycle pulse that stops the sweep.
REQ-011 SHALL have port phase_wrap, input, 1: pulse from the waveform generator at its phase-zero crossing.
REQ-012 SHALL have port freq, output, FREQ_W: the frequency word driven to the waveform generator.
REQ-013 SHALL have port freq_upd, output, 1: one-cycle pulse whenever freq changes.
REQ-014 SHALL have port busy, output, 1: high while a sweep is active.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at normal sweep completion.

Function
REQ-016 SHALL implement states IDLE, RUN, PEND and FIN.
REQ-017 SHALL drive cfg_ready high only in IDLE; cfg_valid&&cfg_ready latches all cfg_* fields in one cycle; cfg_valid in any other state is ignored.
REQ-018 SHALL, on start in IDLE with latched step != 0, load freq=start, pulse freq_upd, set busy and enter RUN on the next cycle; start with step == 0 is ignored.
REQ-019 SHALL set the sweep direction up if start <= stop and down otherwise; start == stop completes after one dwell.
REQ-020 SHALL, in RUN, count dwell cycles, treating dwell == 0 as 1, and enter PEND after the last dwell cycle.
REQ-021 SHALL, in PEND, hold freq until phase_wrap, then apply the next value with a freq_upd pulse on the following cycle, so frequency changes occur only at phase zero.
REQ-022 SHALL compute the next value with FREQ_W+1-bit arithmetic and clamp it to stop whenever the step would pass stop or overflow/underflow.
REQ-023 SHALL, when freq == stop after a dwell, enter FIN, pulse done for one cycle, clear busy and return to IDLE, holding freq at stop.
REQ-024 SHALL, on abort in any non-IDLE state, return to IDLE next cycle with busy=0, freq held and no done pulse.
REQ-025 SHALL give abort priority when abort and start occur in the same cycle.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL, when phase_wrap arrives in the same cycle that PEND is entered, use that phase_wrap.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, freq=0, freq_upd=0, busy=0, done=0, all latched cfg registers=0 and the dwell counter=0, including mid-sweep.

Configuration
REQ-029 SHALL compile ping-pong mode in only when AWG_SWEEP_PINGPONG_EN is defined, adding input port cfg_pingpong (1 bit, latched with the configuration).
REQ-030 SHALL, with AWG_SWEEP_PINGPONG_EN defined and cfg_pingpong=1, reverse direction at each endpoint and repeat indefinitely until abort, never pulsing done.
REQ-031 SHALL, without AWG_SWEEP_PINGPONG_EN, have no cfg_pingpong port and always perform a one-shot sweep.

Structure
REQ-032 SHALL place the state enum type and the default FREQ_W/DWELL_W constants in the shared package awg_pkg.
REQ-033 SHALL implement the clamped next-frequency computation (REQ-022) in the sub-module awg_step_calc.

Verification
REQ-034 SHALL verify an up sweep: start=100, stop=130, step=10, dwell=4, phase_wrap every 8 cycles -> freq sequence 100,110,120,130, each change one cycle after phase_wrap, one done pulse, busy low afterward.
REQ-035 SHALL verify clamping: start=65530, stop=65535, step=10 -> freq 65530 then 65535, no wrap to a small value, done pulse.
REQ-036 SHALL verify a down sweep with abort: start=500, stop=100, step=100, abort asserted while in PEND at freq=400 -> IDLE next cycle, freq stays 400, no done pulse, cfg_ready=1.
REQ-037 SHALL verify the no-op and conflict cases: step=0 with start -> busy stays 0; abort and start in the same cycle in IDLE -> busy stays 0; cfg_valid while busy -> latched configuration unchanged.
REQ-038 SHALL verify reset mid-sweep: rst_n low in RUN at freq=110 -> freq=0, busy=0 immediately, without a clock edge.
REQ-039 SHALL verify ping-pong mode (AWG_SWEEP_PINGPONG_EN): start=0, stop=20, step=10 -> freq 0,10,20,10,0,10,... with no done pulse until abort.
